// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master req/gnt arbiter in front of a single-port
// synchronous-read RAM. Serialises single-beat accesses (one per two cycles)
// and returns read data with a one-cycle rvalid strobe.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// left undefined, master 0 has fixed priority.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic [ADDR_W-1:0] ram_address_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_we;
    logic              r_m0_rvalid;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m0_data;
    logic [DATA_W-1:0] r_m1_data;

    logic              w_any_req;
    logic              w_tie_pick;
    logic              w_winner;
    logic              w_grant;

    assign w_any_req = m0_req_i | m1_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_tie_pick = ~r_last_owner;
`else
    // Fixed priority: master 0 takes every tie; last_owner is tracked but has no say.
    assign w_tie_pick = r_last_owner & 1'b0;
`endif

    // Winner selection: a lone requester wins outright, ties use w_tie_pick
    always_comb begin
        w_winner = 1'b0;
        if (m0_req_i && m1_req_i) begin
            w_winner = w_tie_pick;
        end else if (m1_req_i) begin
            w_winner = 1'b1;
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_any_req;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE waits for a request, ACCESS always lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the winner onto the RAM bus, flag read returns, capture read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_ram_we     <= 1'b0;
            r_m0_rvalid  <= 1'b0;
            r_m1_rvalid  <= 1'b0;
            r_m0_data    <= '0;
            r_m1_data    <= '0;
        end else begin
            r_ram_we    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            if (w_grant) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_ram_addr   <= w_winner ? m1_addr_i : m0_addr_i;
                r_ram_data   <= w_winner ? m1_data_i : m0_data_i;
                r_ram_we     <= w_winner ? m1_we_i   : m0_we_i;
            end
            if ((r_state == S_ACCESS) && !r_ram_we) begin
                r_m0_rvalid <= ~r_owner;
                r_m1_rvalid <= r_owner;
            end
            if (r_m0_rvalid) r_m0_data <= ram_data_i;
            if (r_m1_rvalid) r_m1_data <= ram_data_i;
        end
    end

    assign m0_gnt_o      = (r_state == S_ACCESS) && !r_owner;
    assign m1_gnt_o      = (r_state == S_ACCESS) &&  r_owner;
    assign m0_rvalid_o   = r_m0_rvalid;
    assign m1_rvalid_o   = r_m1_rvalid;
    // RAM data is only present during the rvalid cycle; the register holds it afterwards.
    assign m0_data_o     = r_m0_rvalid ? ram_data_i : r_m0_data;
    assign m1_data_o     = r_m1_rvalid ? ram_data_i : r_m1_data;
    assign ram_address_o = r_ram_addr;
    assign ram_data_o    = r_ram_data;
    assign ram_we_o      = r_ram_we;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural synchronous-read RAM, golden memory
// model and per-master read-data scoreboards.
module tb_ram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [15:0] m0_addr_i = '0;
    logic [7:0]  m0_data_i = '0;
    logic        m0_gnt_o, m0_rvalid_o;
    logic [7:0]  m0_data_o;
    logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [15:0] m1_addr_i = '0;
    logic [7:0]  m1_data_i = '0;
    logic        m1_gnt_o, m1_rvalid_o;
    logic [7:0]  m1_data_o;
    logic [15:0] ram_address_o;
    logic [7:0]  ram_data_o;
    logic        ram_we_o;
    logic [7:0]  ram_data_i;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [0:65535];
    logic [7:0] model [int];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    ram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_data_o(m0_data_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_data_o(m1_data_o),
        .ram_address_o(ram_address_o), .ram_data_o(ram_data_o), .ram_we_o(ram_we_o),
        .ram_data_i(ram_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read single-port RAM
    always @(posedge clk_i) begin
        if (ram_we_o) ram_mem[ram_address_o] <= ram_data_o;
        ram_data_i <= ram_mem[ram_address_o];
    end

    // Read-return monitor: every rvalid must match the oldest expected value
    always @(negedge clk_i) begin
        if (m0_rvalid_o === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL m0_rvalid_unexpected: got rvalid data %02h, required no rvalid", m0_data_o);
            end else begin
                logic [7:0] e0;
                e0 = q0.pop_front();
                if (m0_data_o !== e0) begin
                    errors++;
                    $display("FAIL m0_rdata: got %02h, required %02h", m0_data_o, e0);
                end
            end
        end
        if (m1_rvalid_o === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL m1_rvalid_unexpected: got rvalid data %02h, required no rvalid", m1_data_o);
            end else begin
                logic [7:0] e1;
                e1 = q1.pop_front();
                if (m1_data_o !== e1) begin
                    errors++;
                    $display("FAIL m1_rdata: got %02h, required %02h", m1_data_o, e1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one access, wait (bounded) for its grant, check the RAM bus in the grant cycle.
    // Returns in the grant cycle with req already dropped.
    task automatic do_access(input int m, input logic we, input logic [15:0] addr,
                             input logic [7:0] data, output int waited);
        logic g;
        if (m == 0) begin
            m0_we_i = we; m0_addr_i = addr; m0_data_i = data; m0_req_i = 1'b1;
        end else begin
            m1_we_i = we; m1_addr_i = addr; m1_data_i = data; m1_req_i = 1'b1;
        end
        if (we) model[int'(addr)] = data;
        else if (m == 0) q0.push_back(model[int'(addr)]);
        else q1.push_back(model[int'(addr)]);
        waited = 0;
        g = 1'b0;
        while (!g && waited < 10) begin
            step();
            waited++;
            g = (m == 0) ? m0_gnt_o : m1_gnt_o;
        end
        checks++;
        if (g !== 1'b1) begin
            errors++;
            $display("FAIL gnt_timeout_m%0d: no grant after %0d cycles, required a grant", m, waited);
        end else if (ram_we_o !== we || ram_address_o !== addr || (we && ram_data_o !== data)) begin
            errors++;
            $display("FAIL ram_bus_m%0d: got we=%0b addr=%04h data=%02h, required we=%0b addr=%04h data=%02h",
                     m, ram_we_o, ram_address_o, ram_data_o, we, addr, data);
        end
        if (m == 0) m0_req_i = 1'b0;
        else m1_req_i = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        logic [52:0] v;
        v = {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_data_o, m1_data_o,
             ram_address_o, ram_data_o, ram_we_o};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: got outputs %014h, required all zero", name, v);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("reset_outputs");
        end
        rst_i = 1'b0;
        m0_req_i = 1'b0;
        step();
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_write_read_m0();
        int w;
        do_access(0, 1'b1, 16'h1234, 8'h5A, w);
        checks++;
        if (m1_gnt_o !== 1'b0 || w != 1) begin
            errors++;
            $display("FAIL wr_grant: got m1_gnt=%0b wait=%0d, required m1_gnt=0 wait=1", m1_gnt_o, w);
        end
        step();
        checks++;
        if (ram_we_o !== 1'b0 || m0_gnt_o !== 1'b0 || m0_rvalid_o !== 1'b0 || ram_address_o !== 16'h1234) begin
            errors++;
            $display("FAIL wr_one_cycle: got we=%0b gnt=%0b rvalid=%0b addr=%04h, required 0 0 0 1234",
                     ram_we_o, m0_gnt_o, m0_rvalid_o, ram_address_o);
        end
        do_access(0, 1'b0, 16'h1234, 8'h00, w);
        step();
        checks++;
        if (m0_rvalid_o !== 1'b1 || w != 1) begin
            errors++;
            $display("FAIL rd_latency: got rvalid=%0b wait=%0d, required rvalid=1 wait=1", m0_rvalid_o, w);
        end
        step();
        checks++;
        if (m0_rvalid_o !== 1'b0 || m0_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL rd_hold: got rvalid=%0b data=%02h, required rvalid=0 data=5a", m0_rvalid_o, m0_data_o);
        end
    endtask

    task automatic test_contention();
        int w;
        logic exp0, exp1;
        do_access(0, 1'b1, 16'h0010, 8'h11, w);
        step();
        do_access(1, 1'b1, 16'h0020, 8'h22, w);
        step();
        m0_we_i = 1'b0; m0_addr_i = 16'h0010;
        m1_we_i = 1'b0; m1_addr_i = 16'h0020;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp0 = 1'b0; exp1 = 1'b0;
            if (k % 2 == 1) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (((k - 1) / 2) % 2 == 0) exp0 = 1'b1; else exp1 = 1'b1;
`else
                exp0 = 1'b1;
`endif
            end
            if (m0_gnt_o === 1'b1) q0.push_back(model[32'h10]);
            if (m1_gnt_o === 1'b1) q1.push_back(model[32'h20]);
            checks++;
            if (m0_gnt_o !== exp0 || m1_gnt_o !== exp1) begin
                errors++;
                $display("FAIL contention_cycle%0d: got gnt0=%0b gnt1=%0b, required gnt0=%0b gnt1=%0b",
                         k, m0_gnt_o, m1_gnt_o, exp0, exp1);
            end
            if (k == 7) begin
                m0_req_i = 1'b0; m1_req_i = 1'b0;
            end
        end
        step();
        step();
    endtask

    task automatic test_write_isolation();
        int w;
        do_access(1, 1'b1, 16'hFFFF, 8'hA5, w);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m0_gnt_o !== 1'b0 || m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL isolation_cycle%0d: got gnt0=%0b rv0=%0b rv1=%0b, required all 0",
                         i, m0_gnt_o, m0_rvalid_o, m1_rvalid_o);
            end
            step();
        end
        do_access(0, 1'b0, 16'hFFFF, 8'h00, w);
        step();
        checks++;
        if (m0_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL isolation_readback: got rvalid=%0b, required 1", m0_rvalid_o);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        int w;
        do_access(1, 1'b0, 16'h0020, 8'h00, w);
        step();
        step();
        // Read whose rvalid must be suppressed: no scoreboard entry is pushed
        m1_we_i = 1'b0; m1_addr_i = 16'hFFFF; m1_req_i = 1'b1;
        step();
        checks++;
        if (m1_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got m1_gnt=%0b, required 1", m1_gnt_o);
        end
        rst_i = 1'b1;
        m1_req_i = 1'b0;
        step();
        check_all_zero("midrst_outputs");
        rst_i = 1'b0;
        do_access(1, 1'b0, 16'h0010, 8'h00, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL midrst_regrant: got wait=%0d, required 1", w);
        end
        step();
        checks++;
        if (m1_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rvalid: got rvalid=%0b, required 1", m1_rvalid_o);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read_m0();
        test_contention();
        test_write_isolation();
        test_reset_mid_access();
        step();
        step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending reads, required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
